clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting controller for the digital clock. It takes two push-button inputs (mode, increment) and the 1 Hz tick, and sequences the seconds, minutes and hours counters. It drives the seconds counter's `key` run-enable, issues single-cycle increment/clear pulses to the counters, and provides a blink flag for the display of the field being edited. It sits between the button pads and the `generateSec`/minute/hour counter chain.

## Interface
Parameters:
- `TIMEOUT_S`, 30: ticks of inactivity in any SET state before returning to RUN; legal 2..255.
- `REPEAT_DLY`, 2: ticks `inc_key` must stay held before auto-repeat starts; legal 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  single-cycle pulse, the same tick that advances seconds.
- `mode_key`  in  1  raw mode button level, active-high, asynchronous.
- `inc_key`  in  1  raw increment button level, active-high, asynchronous.
- `key`  out  1  seconds-counter run enable: 1 = count, 0 = hold.
- `sec_clr`  out  1  single-cycle pulse that zeroes the seconds digits.
- `min_inc`  out  1  single-cycle pulse that increments minutes by one, without carry into hours.
- `hr_inc`  out  1  single-cycle pulse that increments hours by one.
- `mode`  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- `blink`  out  1  display blank flag for the selected field.

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector. "Press" means a one-cycle rising edge on the synchronized level.
- FSM:
  - RUN → SET_HR on a mode press.
  - SET_HR → SET_MIN on a mode press.
  - SET_MIN → SET_SEC on a mode press.
  - SET_SEC → RUN on a mode press.
  - Any SET state → RUN when the idle count reaches `TIMEOUT_S`.
- `key` is 1 only in RUN, so seconds are frozen during setting.
- Inc press by state:
  - SET_HR: pulse `hr_inc`.
  - SET_MIN: pulse `min_inc`.
  - SET_SEC: pulse `sec_clr`.
  - RUN: ignored.
- Auto-repeat:
  - A held-tick counter counts `tick_1hz` while the synchronized `inc_key` is high in a SET state.
  - Once the counter reaches `REPEAT_DLY`, every further tick emits one increment pulse for the current state.
  - The counter clears on release or on any state change.
  - SET_SEC never repeats; `sec_clr` fires once per press.
- Idle counter (8 bit):
  - Clears on any press and on any state change.
  - Increments on `tick_1hz` while in a SET state and `inc_key` is released.
  - Saturates; never wraps.
- `blink` toggles on each `tick_1hz` in SET states. It is forced to 0 in RUN and on every state change.

## Timing
- Reset values: `mode`=RUN, `key`=1, `sec_clr`=`min_inc`=`hr_inc`=0, `blink`=0, all counters 0, synchronizer flops 0.
- All outputs are registered.
- Latency: a raw button going high before clock edge n gives a state/pulse change visible after edge n+3. The level must stay high for at least 3 cycles to register.
- Pulses are exactly one cycle wide. At most one of `sec_clr`/`min_inc`/`hr_inc` is high in any cycle.
- Simultaneous events:
  - Mode press and inc press in the same cycle: mode wins, inc is discarded.
  - Press and tick in the same cycle: idle clears, the tick is not counted.
  - Timeout and press in the same cycle: the press wins, no timeout.
- Auto-repeat pulse and a new press cannot coincide, because a press requires a release first.
- Reset asserted mid-operation: immediate return to the reset values. Any pulse in flight is dropped.
- Idle count reaching `TIMEOUT_S` returns to RUN on the next edge. `key` rises in that same cycle.

## Structure
- Shared package `clock_pkg` holds:
  - `mode_t`, a 2-bit enum (RUN, SET_HR, SET_MIN, SET_SEC).
  - Default constants for `TIMEOUT_S` and `REPEAT_DLY`.
- Sub-module `key_sync_edge` (synchronizer plus rise detector, outputs `level` and `rise`), instantiated once per button.
- The top level holds the FSM, the repeat counter, the idle counter and the output registers.

## Test plan
- Reset then release: `mode`=0, `key`=1, no pulses. Four mode presses step `mode` 1,2,3,0. `key`=0 in states 1–3.
- In SET_HR, three inc presses produce exactly three one-cycle `hr_inc` pulses, each 3 cycles after its raw rise. Zero `min_inc`/`sec_clr`.
- In SET_MIN, hold inc for 6 ticks with `REPEAT_DLY`=2: 1 press pulse plus 4 repeat pulses on `min_inc`, for a total of 5.
- In SET_SEC with `TIMEOUT_S`=3 and no presses: return to RUN on the edge after the 3rd tick. `key`=1 and `blink`=0 there.
- Mode and inc raised in the same cycle while in SET_HR: `mode`→2 and no `hr_inc` pulse. Reset asserted mid-hold: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default constants for the digital-clock time-setting logic.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } mode_t;

   localparam int unsigned TIMEOUT_S_DEF  = 30;
   localparam int unsigned REPEAT_DLY_DEF = 2;

   // Mode-button sequence: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      unique case (m)
         RUN:     r = SET_HR;
         SET_HR:  r = SET_MIN;
         SET_MIN: r = SET_SEC;
         SET_SEC: r = RUN;
         default: r = RUN;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus a registered rising-edge detector for one raw button.
// level and rise go high together, three edges after the raw input is first sampled.
module key_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s3   <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_s1   <= din;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_rise <= r_s2 & ~r_s3;
      end
   end

   assign level = r_s3;
   assign rise  = r_rise;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode/inc buttons step through the set fields, emit
// single-cycle counter pulses with auto-repeat, and time out back to RUN.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_S  = TIMEOUT_S_DEF,
   parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       mode_key,
   input  logic       inc_key,
   output logic       key,
   output logic       sec_clr,
   output logic       min_inc,
   output logic       hr_inc,
   output logic [1:0] mode,
   output logic       blink
);

   localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_S);
   localparam logic [3:0] LP_REPEAT  = 4'(REPEAT_DLY);
   localparam logic [7:0] LP_IDLE_MAX = 8'hFF;

   // Synchronized button levels and presses
   logic w_mode_lvl_unused;
   logic w_mode_rise;
   logic w_inc_lvl;
   logic w_inc_rise;

   key_sync_edge u_mode_sync (
      .clk   (clk),
      .reset (reset),
      .din   (mode_key),
      .level (w_mode_lvl_unused),
      .rise  (w_mode_rise)
   );

   key_sync_edge u_inc_sync (
      .clk   (clk),
      .reset (reset),
      .din   (inc_key),
      .level (w_inc_lvl),
      .rise  (w_inc_rise)
   );

   // State and output registers
   mode_t      r_mode;
   logic [7:0] r_idle;
   logic [3:0] r_hold;
   logic       r_key;
   logic       r_sec_clr;
   logic       r_min_inc;
   logic       r_hr_inc;
   logic       r_blink;

   // Next-state values
   mode_t      w_mode_nxt;
   logic [7:0] w_idle_nxt;
   logic [3:0] w_hold_nxt;
   logic       w_key_nxt;
   logic       w_sec_clr_nxt;
   logic       w_min_inc_nxt;
   logic       w_hr_inc_nxt;
   logic       w_blink_nxt;

   logic       w_set;
   logic       w_inc_press;
   logic       w_timeout;
   logic       w_state_chg;
   logic       w_repeat;
   logic       w_fire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode    <= RUN;
         r_idle    <= '0;
         r_hold    <= '0;
         r_key     <= 1'b1;
         r_sec_clr <= 1'b0;
         r_min_inc <= 1'b0;
         r_hr_inc  <= 1'b0;
         r_blink   <= 1'b0;
      end else begin
         r_mode    <= w_mode_nxt;
         r_idle    <= w_idle_nxt;
         r_hold    <= w_hold_nxt;
         r_key     <= w_key_nxt;
         r_sec_clr <= w_sec_clr_nxt;
         r_min_inc <= w_min_inc_nxt;
         r_hr_inc  <= w_hr_inc_nxt;
         r_blink   <= w_blink_nxt;
      end
   end

   always_comb begin
      w_set       = (r_mode != RUN);
      // A mode press in the same cycle swallows the inc press.
      w_inc_press = w_inc_rise & ~w_mode_rise;
      // Any press in the timeout cycle keeps the controller in its SET state.
      w_timeout   = w_set && (r_idle >= LP_TIMEOUT) && !w_mode_rise && !w_inc_rise;

      w_mode_nxt = r_mode;
      if (w_mode_rise) begin
         w_mode_nxt = next_mode(r_mode);
      end else if (w_timeout) begin
         w_mode_nxt = RUN;
      end
      w_state_chg = (w_mode_nxt != r_mode);
      w_key_nxt   = (w_mode_nxt == RUN);

      // Held-tick counter saturates at REPEAT_DLY; each later tick is a repeat.
      w_hold_nxt = r_hold;
      w_repeat   = 1'b0;
      if (w_state_chg || !w_inc_lvl || !w_set) begin
         w_hold_nxt = '0;
      end else if (tick_1hz) begin
         if (r_hold < LP_REPEAT) begin
            w_hold_nxt = r_hold + 4'd1;
         end else begin
            w_repeat = (r_mode != SET_SEC);
         end
      end

      w_idle_nxt = r_idle;
      if (w_mode_rise || w_inc_rise || w_state_chg) begin
         w_idle_nxt = '0;
      end else if (tick_1hz && w_set && !w_inc_lvl && (r_idle != LP_IDLE_MAX)) begin
         w_idle_nxt = r_idle + 8'd1;
      end

      w_fire        = ((w_inc_press && w_set) || w_repeat) && !w_state_chg;
      w_hr_inc_nxt  = w_fire && (r_mode == SET_HR);
      w_min_inc_nxt = w_fire && (r_mode == SET_MIN);
      w_sec_clr_nxt = w_fire && (r_mode == SET_SEC);

      w_blink_nxt = r_blink;
      if (w_state_chg || (w_mode_nxt == RUN)) begin
         w_blink_nxt = 1'b0;
      end else if (tick_1hz) begin
         w_blink_nxt = ~r_blink;
      end
   end

   assign key     = r_key;
   assign sec_clr = r_sec_clr;
   assign min_inc = r_min_inc;
   assign hr_inc  = r_hr_inc;
   assign mode    = r_mode;
   assign blink   = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected pulses are queued with their
// expected cycle when buttons/ticks are driven, and matched as the DUT emits them.
module tb_clock_set_ctrl;

   localparam int unsigned TIMEOUT_S  = 3;
   localparam int unsigned REPEAT_DLY = 2;

   logic       clk;
   logic       reset;
   logic       tick_1hz;
   logic       mode_key;
   logic       inc_key;
   logic       key;
   logic       sec_clr;
   logic       min_inc;
   logic       hr_inc;
   logic [1:0] mode;
   logic       blink;

   clock_set_ctrl #(
      .TIMEOUT_S  (TIMEOUT_S),
      .REPEAT_DLY (REPEAT_DLY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick_1hz (tick_1hz),
      .mode_key (mode_key),
      .inc_key  (inc_key),
      .key      (key),
      .sec_clr  (sec_clr),
      .min_inc  (min_inc),
      .hr_inc   (hr_inc),
      .mode     (mode),
      .blink    (blink)
   );

   typedef struct {
      logic [2:0] kind;  // {sec_clr, min_inc, hr_inc}
      int         cyc;
   } ev_t;

   ev_t        sb[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_err = 0;
   logic [1:0] exp_mode = 2'd0;
   logic       exp_blink = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] kind_of(input logic [1:0] m);
      logic [2:0] k;
      case (m)
         2'd1:    k = 3'b001;
         2'd2:    k = 3'b010;
         2'd3:    k = 3'b100;
         default: k = 3'b000;
      endcase
      return k;
   endfunction

   // Pulse monitor: every observed pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      logic [2:0] seen;
      ev_t        e;
      seen = {sec_clr, min_inc, hr_inc};
      if (seen != 3'b000) begin
         if (sb.size() == 0) begin
            check_val("unexpected_pulse", 32'(seen), 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("pulse_kind", 32'(seen), 32'(e.kind));
            check_val("pulse_cyc", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg(input int target);
      @(negedge clk);
      while (cyc < target) @(negedge clk);
   endtask

   // Raise the chosen buttons for several cycles, checking the 3-edge latency.
   task automatic press(input logic m, input logic i);
      int         d;
      logic [1:0] old_mode;
      step();
      mode_key = m;
      inc_key  = i;
      d        = cyc;
      old_mode = exp_mode;
      if (!m && i && exp_mode != 2'd0) sb.push_back('{kind_of(exp_mode), d + 4});
      wait_neg(d + 3);
      check_val("mode_latency", 32'(mode), 32'(old_mode));
      if (m) begin
         exp_mode  = exp_mode + 2'd1;
         exp_blink = 1'b0;
      end
      wait_neg(d + 4);
      check_val("mode", 32'(mode), 32'(exp_mode));
      check_val("key", 32'(key), 32'(exp_mode == 2'd0));
      check_val("blink", 32'(blink), 32'(exp_blink));
      step();
      mode_key = 1'b0;
      inc_key  = 1'b0;
      repeat (5) step();
   endtask

   // One tick_1hz pulse; rep queues the auto-repeat pulse it should cause.
   task automatic tick(input logic rep, output int t);
      step();
      tick_1hz = 1'b1;
      t = cyc;
      if (rep) sb.push_back('{kind_of(exp_mode), t + 1});
      if (exp_mode != 2'd0) exp_blink = ~exp_blink;
      step();
      tick_1hz = 1'b0;
      wait_neg(t + 1);
      check_val("blink_tick", 32'(blink), 32'(exp_blink));
   endtask

   task automatic hold_inc(input int nticks);
      int d;
      int t;
      step();
      inc_key = 1'b1;
      d = cyc;
      sb.push_back('{kind_of(exp_mode), d + 4});
      repeat (6) step();
      for (int k = 1; k <= nticks; k++) begin
         tick((k > int'(REPEAT_DLY)) && (exp_mode != 2'd3), t);
         repeat (2) step();
      end
      step();
      inc_key = 1'b0;
      repeat (6) step();
      check_val("sb_drain_hold", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int t;
      int d;
      reset    = 1'b0;
      tick_1hz = 1'b0;
      mode_key = 1'b0;
      inc_key  = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check_val("rst_mode", 32'(mode), 32'd0);
      check_val("rst_key", 32'(key), 32'd1);
      check_val("rst_blink", 32'(blink), 32'd0);
      check_val("rst_pulses", 32'({sec_clr, min_inc, hr_inc}), 32'd0);
      step();
      reset = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check_val("post_rst_mode", 32'(mode), 32'd0);
      check_val("post_rst_key", 32'(key), 32'd1);

      // Inc in RUN is ignored; then a full mode cycle 1,2,3,0.
      press(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) press(1'b1, 1'b0);

      // Three hr_inc presses in SET_HR.
      press(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) press(1'b0, 1'b1);
      check_val("sb_drain_hr", 32'(sb.size()), 32'd0);

      // SET_MIN hold for 6 ticks: 1 press + 4 repeats.
      press(1'b1, 1'b0);
      hold_inc(6);

      // SET_SEC hold: a single sec_clr, no repeats.
      press(1'b1, 1'b0);
      hold_inc(4);

      // Timeout from SET_SEC after 3 idle ticks.
      for (int k = 1; k <= 3; k++) begin
         tick(1'b0, t);
         check_val("timeout_not_yet", 32'(mode), 32'd3);
         if (k < 3) repeat (2) step();
      end
      exp_mode  = 2'd0;
      exp_blink = 1'b0;
      wait_neg(t + 2);
      check_val("timeout_mode", 32'(mode), 32'd0);
      check_val("timeout_key", 32'(key), 32'd1);
      check_val("timeout_blink", 32'(blink), 32'd0);

      // Mode and inc together in SET_HR: mode wins, no hr_inc.
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);

      // Reset mid-hold while a min_inc pulse is in flight.
      tick(1'b0, t);
      step();
      inc_key = 1'b1;
      d = cyc;
      while (cyc < d + 4) step();
      check_val("inflight_pulse", 32'(min_inc), 32'd1);
      check_val("inflight_blink", 32'(blink), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_val("arst_mode", 32'(mode), 32'd0);
      check_val("arst_key", 32'(key), 32'd1);
      check_val("arst_pulses", 32'({sec_clr, min_inc, hr_inc}), 32'd0);
      check_val("arst_blink", 32'(blink), 32'd0);
      exp_mode  = 2'd0;
      exp_blink = 1'b0;
      inc_key   = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check_val("final_mode", 32'(mode), 32'd0);
      check_val("final_key", 32'(key), 32'd1);
      check_val("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
